// File: rtl/regfile_dump_engine_if.sv
// Output stream of the register dump engine: one register (or checksum) word per beat.
// master = dump engine, slave = sink.
interface regfile_dump_engine_if #(
    parameter int N      = 32,
    parameter int ADDR_W = 5
);
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    modport master (output out_valid, output out_data, output out_addr, output out_last,
                    input  out_ready);
    modport slave  (input  out_valid, input  out_data, input  out_addr, input  out_last,
                    output out_ready);
endinterface

// File: rtl/regfile_dump_engine.sv
// Read-side dump sequencer for the 32xN register file: reads register pairs via A1/A2 and
// streams them one per beat. Define REGDUMP_CHECKSUM_EN to append an XOR checksum beat.
module regfile_dump_engine #(
    parameter int N      = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] A1,
    output logic [ADDR_W-1:0] A2,
    input  logic [N-1:0]      RD1,
    input  logic [N-1:0]      RD2,
    regfile_dump_engine_if.master stream
);

`ifdef REGDUMP_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, FETCH, SEND0, SEND1, CSUM, FIN} state_t;

    state_t            state;
    logic [N-1:0]      buf1;
    logic [ADDR_W-1:0] stop_addr;
    logic              handshake;
    logic              at_last;
`ifdef REGDUMP_CHECKSUM_EN
    logic [N-1:0]      csum;
`endif

    assign handshake = stream.out_valid && stream.out_ready;
    assign at_last   = (state == SEND0) ? (A1 == stop_addr) : (A2 == stop_addr);

    // The even word goes straight into out_data at the end of FETCH; only the odd word needs a buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            A1               <= '0;
            A2               <= '0;
            buf1             <= '0;
            stop_addr        <= '0;
            stream.out_valid <= 1'b0;
            stream.out_data  <= '0;
            stream.out_addr  <= '0;
            stream.out_last  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum             <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        stop_addr <= last_addr;
                        A1        <= first_addr;
                        A2        <= first_addr + ADDR_W'(1);
`ifdef REGDUMP_CHECKSUM_EN
                        csum      <= '0;
`endif
                        if (first_addr > last_addr) begin
`ifdef REGDUMP_CHECKSUM_EN
                            state            <= CSUM;
                            busy             <= 1'b1;
                            stream.out_valid <= 1'b1;
                            stream.out_data  <= '0;
                            stream.out_addr  <= '1;
                            stream.out_last  <= 1'b1;
`else
                            state <= FIN;
                            done  <= 1'b1;
`endif
                        end else begin
                            state <= FETCH;
                            busy  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    buf1             <= RD2;
                    stream.out_data  <= RD1;
                    stream.out_addr  <= A1;
                    stream.out_last  <= !CSUM_EN && (A1 == stop_addr);
                    stream.out_valid <= 1'b1;
                    state            <= SEND0;
                end
                SEND0, SEND1: begin
                    if (handshake) begin
`ifdef REGDUMP_CHECKSUM_EN
                        csum <= csum ^ stream.out_data;
`endif
                        if (at_last) begin
`ifdef REGDUMP_CHECKSUM_EN
                            state           <= CSUM;
                            stream.out_data <= csum ^ stream.out_data;
                            stream.out_addr <= '1;
                            stream.out_last <= 1'b1;
`else
                            state            <= FIN;
                            stream.out_valid <= 1'b0;
                            stream.out_last  <= 1'b0;
                            done             <= 1'b1;
                            busy             <= 1'b0;
`endif
                        end else if (state == SEND0) begin
                            state           <= SEND1;
                            stream.out_data <= buf1;
                            stream.out_addr <= A2;
                            stream.out_last <= !CSUM_EN && (A2 == stop_addr);
                        end else begin
                            state            <= FETCH;
                            stream.out_valid <= 1'b0;
                            A1               <= A1 + ADDR_W'(2);
                            A2               <= A2 + ADDR_W'(2);
                        end
                    end
                end
                CSUM: begin
                    if (handshake) begin
                        state            <= FIN;
                        stream.out_valid <= 1'b0;
                        stream.out_last  <= 1'b0;
                        done             <= 1'b1;
                        busy             <= 1'b0;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
